mandelbrot_pixel_streamer: RTL
==============================

// Module: mandelbrot_pixel_streamer
// PURPOSE
//  Downstream consumer of the mandelbrot iteration engine. Sequences the engine pixel by pixel
//  (run/running handshake) and captures each 4-bit ctr_out. Packs two pixels per byte and
//  buffers bytes in a small FIFO. Presents them on a valid/ready byte stream with
//  start-of-frame and end-of-line flags for the output/IO stage.
// PARAMETERS
//  WIDTH       320  pixels per line; must be even and match the engine's WIDTH
//  HEIGHT      240  lines per frame; must match the engine's HEIGHT
//  FIFO_DEPTH  4    output FIFO entries (bytes + flags); power of two, >= 2
// PORTS
//  clk          in   1  clock
//  rst_n        in   1  asynchronous active-low reset
//  enable       in   1  start a frame; sampled only in IDLE
//  mb_run       out  1  run pulse to the engine
//  mb_running   in   1  engine busy on the current pixel
//  mb_finished  in   1  engine frame-finished flag
//  mb_ctr       in   4  engine ctr_out; valid once mb_running has fallen
//  out_data     out  8  {pixel x+1, pixel x}; even-x pixel in [3:0]
//  out_sof      out  1  marks the first byte of a frame; qualified by out_valid
//  out_eol      out  1  marks the last byte of a line; qualified by out_valid
//  out_valid    out  1  FIFO not empty
//  out_ready    in   1  sink accepts the byte when out_valid && out_ready
//  busy         out  1  FSM not in IDLE
//  frame_done   out  1  one-cycle pulse when the last pixel of a frame is captured
//  sync_error   out  1  sticky; cleared only by reset or the next frame start
// BEHAVIOUR
//  Reset values: mb_run=0, busy=0, frame_done=0, sync_error=0, out_valid=0.
//   out_data, out_sof and out_eol are 0. FIFO empty, x=0, y=0, pack register empty.
//  Reset is asynchronous and may arrive mid-frame or mid-pixel. It returns to IDLE immediately.
//   The engine is reset by the same rst_n, so no resynchronisation is needed.
//  FSM states:
//   IDLE:  when enable=1, clear x, y and sync_error, then go to ISSUE.
//   ISSUE: wait until the FIFO is not full. Then drive mb_run=1 for exactly one cycle
//          and go to START.
//   START: wait for mb_running=1, then go to DONE. The engine raises running the cycle
//          after run.
//   DONE:  wait for mb_running=0 and capture mb_ctr in that same cycle.
//    Even x: store the pixel in the pack register.
//    Odd x: push {mb_ctr, pack} with these flags:
//     sof = (x==1 && y==0)
//     eol = (x==WIDTH-1)
//   After DONE, advance x; at x==WIDTH-1 wrap x to 0 and increment y.
//    If x==WIDTH-1 && y==HEIGHT-1: go to IDLE and pulse frame_done. Otherwise go to ISSUE.
//  The enable level does not affect an active frame. Frames never abort except by reset.
//  No new mb_run is issued while the FIFO is full. This stalls the engine, so no pixel is
//   ever dropped. FIFO is not full in ISSUE, so a push never finds it full.
//  sync_error is set at the final capture in either of these cases:
//   - mb_finished=0 at that capture;
//   - mb_finished=1 at any earlier capture.
//  FIFO rules:
//   - Push and pop in the same cycle leave the count unchanged.
//   - A pop with the FIFO empty is ignored.
//   - Pointers wrap modulo FIFO_DEPTH, with one extra bit to tell full from empty.
//  Output handshake:
//   - out_data, out_sof and out_eol are the FIFO head. They are stable while
//     out_valid && !out_ready.
//   - First-word fall-through: out_valid rises the cycle after a push into an empty FIFO.
//  Throughput: at most one pixel per engine iteration run, plus 3 cycles of handshake
//   overhead per pixel.
// STRUCTURE
//  Shared package or defines: FSM state encoding (IDLE/ISSUE/START/DONE), PIXEL_BITS=4,
//   and the default WIDTH/HEIGHT shared with the engine.
//  Sub-module: mandelbrot_pixel_fifo. Synchronous FIFO, 10 bits wide ({sof, eol, data}),
//   depth FIFO_DEPTH, with full/empty flags. The FSM, counters and pack register stay
//   in this module.
// TESTING  (engine BFM; WIDTH=4, HEIGHT=2 unless stated)
//  1. Reset, enable=1, BFM returns ctr 1..8 with out_ready=1:
//     bytes 0x21(sof), 0x43(eol), 0x65, 0x87(eol).
//     frame_done pulses once; busy falls; sync_error=0.
//  2. out_ready=0 for the whole frame, FIFO_DEPTH=2:
//     exactly 4 mb_run pulses, then mb_run stays low while out_valid=1 and data is stable.
//     Raise out_ready: all 4 bytes arrive in order and the frame completes.
//  3. BFM holds mb_running high 50 cycles per pixel:
//     no extra mb_run; capture occurs the cycle running falls; byte values are correct.
//  4. BFM asserts mb_finished after pixel 4 of 8:
//     sync_error=1 at frame end. The next enable clears it and a clean frame leaves it 0.
//  5. Assert rst_n low in DONE of pixel 3 during a push/pop cycle:
//     all outputs take reset values immediately. A new frame then starts at x=0,y=0 with sof.
//  6. WIDTH=320, HEIGHT=240 full frame, random out_ready:
//     38400 bytes; 240 eol flags; one sof; byte order matches the reference model.

Source files
------------

// File: rtl/mandelbrot_pixel_streamer_pkg.sv
// Shared types and constants for the mandelbrot pixel streamer and its FIFO.
// Default frame geometry matches the iteration engine.
package mandelbrot_pixel_streamer_pkg;

  localparam int unsigned PIXEL_BITS     = 4;
  localparam int unsigned DEFAULT_WIDTH  = 320;
  localparam int unsigned DEFAULT_HEIGHT = 240;
  localparam int unsigned BYTE_BITS      = 2 * PIXEL_BITS;
  localparam int unsigned FIFO_BITS      = BYTE_BITS + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_START,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic                 sof;
    logic                 eol;
    logic [BYTE_BITS-1:0] data;
  } fifo_word_t;

endpackage

// File: rtl/mandelbrot_pixel_streamer_if.sv
// Valid/ready byte stream carrying packed pixel pairs with frame/line flags.
interface mandelbrot_pixel_streamer_if;
  import mandelbrot_pixel_streamer_pkg::*;

  logic [BYTE_BITS-1:0] out_data;
  logic                 out_sof;
  logic                 out_eol;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_data, out_sof, out_eol, out_valid, input out_ready);
  modport slave  (input out_data, out_sof, out_eol, out_valid, output out_ready);

endinterface

// File: rtl/mandelbrot_pixel_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero while empty.
module mandelbrot_pixel_fifo #(
  parameter int unsigned DATA_BITS = 10,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] head,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mandelbrot_pixel_streamer.sv
// Sequences the mandelbrot engine pixel by pixel, packs pixel pairs into bytes
// and streams them through a small FIFO with start-of-frame / end-of-line flags.
module mandelbrot_pixel_streamer
  import mandelbrot_pixel_streamer_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned HEIGHT     = DEFAULT_HEIGHT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  mb_run,
  input  logic                  mb_running,
  input  logic                  mb_finished,
  input  logic [PIXEL_BITS-1:0] mb_ctr,
  mandelbrot_pixel_streamer_if.master stream,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  sync_error
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT + 1);

  state_t                state;
  state_t                state_nx;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [PIXEL_BITS-1:0] pack;
  logic                  fin_seen;
  logic                  capture;
  logic                  last_x;
  logic                  last_px;
  logic                  fifo_full;
  logic                  fifo_empty;
  fifo_word_t            push_w;
  fifo_word_t            head_w;

  assign last_x  = (x == XW'(WIDTH - 1));
  assign last_px = last_x && (y == YW'(HEIGHT - 1));
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    mb_run     = '0;
    capture    = '0;
    frame_done = '0;
    unique case (state)
      ST_IDLE:  if (enable) state_nx = ST_ISSUE;
      ST_ISSUE: if (!fifo_full) begin
        mb_run   = '1;
        state_nx = ST_START;
      end
      ST_START: if (mb_running) state_nx = ST_DONE;
      ST_DONE:  if (!mb_running) begin
        capture    = '1;
        frame_done = last_px;
        state_nx   = last_px ? ST_IDLE : ST_ISSUE;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  // fin_seen remembers an early finished flag so the final capture can flag it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x          <= '0;
      y          <= '0;
      pack       <= '0;
      sync_error <= '0;
      fin_seen   <= '0;
    end else if (state == ST_IDLE && enable) begin
      x          <= '0;
      y          <= '0;
      sync_error <= '0;
      fin_seen   <= '0;
    end else if (capture) begin
      if (!x[0]) pack <= mb_ctr;
      if (last_px) begin
        if (!mb_finished || fin_seen) sync_error <= '1;
      end else if (mb_finished) begin
        fin_seen <= '1;
      end
      if (last_x) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign push_w.sof  = (x == XW'(1)) && (y == '0);
  assign push_w.eol  = last_x;
  assign push_w.data = {mb_ctr, pack};

  mandelbrot_pixel_fifo #(
    .DATA_BITS (FIFO_BITS),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture && x[0]),
    .push_data (push_w),
    .pop       (stream.out_ready),
    .head      (head_w),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign stream.out_data  = head_w.data;
  assign stream.out_sof   = head_w.sof;
  assign stream.out_eol   = head_w.eol;
  assign stream.out_valid = !fifo_empty;

endmodule
